// File: rtl/game_flow_pkg.sv
// Package: game_flow_pkg
// Shared types and constants for the dungeon game-flow sequencer.
//   flow_state_t  : the nine game-flow states
//   KEY_ENTER     : HID code for Enter (leaves the title screen)
//   KEY_R         : HID code for R (restarts after win/death)
//   HEALTH_W      : width of the player health counter
//   FRAME_CNT_W   : width of the frame-tick counter
//   key_match()   : true when either byte of a two-byte keycode equals a key
package game_flow_pkg;

   localparam int HEALTH_W    = 3;
   localparam int FRAME_CNT_W = 8;

   localparam logic [7:0] KEY_ENTER = 8'h28;
   localparam logic [7:0] KEY_R     = 8'h15;

   typedef enum logic [3:0] {
      ST_INIT,
      ST_LVL1,
      ST_DOOR1,
      ST_LVL2,
      ST_DOOR2,
      ST_LVL3,
      ST_DOOR3,
      ST_WIN,
      ST_DEAD
   } flow_state_t;

   function automatic logic key_match(input logic [15:0] keycode, input logic [7:0] key);
      return (keycode[15:8] == key) || (keycode[7:0] == key);
   endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Module: frame_tick_gen
// Turns the vsync-rate frame_clk strobe into a single-cycle frame tick in the
// Clk domain and runs one clearable, loadable frame-tick counter on it.
// The counter counts up (saturating at all-ones) or down (stopping at zero),
// advancing only on frame ticks.
// Ports:
//   Clk, Reset   in   clock, synchronous active-high reset
//   frame_clk    in   vsync-rate strobe
//   clr          in   clear counter to 0 (highest priority after Reset)
//   load         in   load counter with load_val
//   load_val     in   FRAME_CNT_W value to load
//   count_down   in   1: count down on ticks, 0: count up on ticks
//   count        out  FRAME_CNT_W counter value
module frame_tick_gen
   import game_flow_pkg::*;
(
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   frame_clk,
   input  logic                   clr,
   input  logic                   load,
   input  logic [FRAME_CNT_W-1:0] load_val,
   input  logic                   count_down,
   output logic [FRAME_CNT_W-1:0] count
);

   localparam logic [FRAME_CNT_W-1:0] CNT_ONE = FRAME_CNT_W'(1);

   logic frame_clk_q;
   logic frame_tick;

   always_ff @(posedge Clk) begin
      if (Reset) frame_clk_q <= 1'b0;
      else       frame_clk_q <= frame_clk;
   end

   // Rising edge of frame_clk, one Clk cycle wide.
   assign frame_tick = frame_clk & ~frame_clk_q;

   always_ff @(posedge Clk) begin
      if (Reset || clr) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (frame_tick) begin
         if (count_down) begin
            if (count != '0) count <= count - CNT_ONE;
         end else if (count != '1) begin
            count <= count + CNT_ONE;
         end
      end
   end

endmodule

// File: rtl/dungeon_flow_ctrl.sv
// Module: dungeon_flow_ctrl
// Game-flow sequencer: title -> level 1..3 with door transitions -> win, or
// death screen when health runs out. Drives one-hot level/door enables, owns
// the player health counter and emits a one-cycle soft_reset on restart.
// Optional feature macro: DMG_INVULN_EN (hit immunity for INVULN_FRAMES ticks
// after each accepted hit). Default build has no immunity.
// Ports:
//   Clk, Reset      in   clock, synchronous active-high reset
//   frame_clk       in   vsync-rate strobe
//   keycode[15:0]   in   two HID key bytes
//   finish[2:0]     in   level n+1 cleared
//   hit[2:0]        in   player struck in level n+1
//   level_active    out  one-hot running level
//   door_active     out  one-hot door transition after level n+1
//   initial_frame   out  title screen
//   final_frame     out  win screen
//   game_over       out  death screen
//   soft_reset      out  one-cycle restart pulse
//   active_key      out  any key byte nonzero
//   Health[2:0]     out  current health
module dungeon_flow_ctrl
   import game_flow_pkg::*;
#(
   parameter logic [7:0]          START_KEY     = KEY_ENTER,
   parameter logic [7:0]          RESTART_KEY   = KEY_R,
   parameter int                  DOOR_FRAMES   = 60,
   parameter logic [HEALTH_W-1:0] HEALTH_MAX    = 3'd7,
   parameter int                  INVULN_FRAMES = 30
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic                frame_clk,
   input  logic [15:0]         keycode,
   input  logic [2:0]          finish,
   input  logic [2:0]          hit,
   output logic [2:0]          level_active,
   output logic [2:0]          door_active,
   output logic                initial_frame,
   output logic                final_frame,
   output logic                game_over,
   output logic                soft_reset,
   output logic                active_key,
   output logic [HEALTH_W-1:0] Health
);

   localparam logic [FRAME_CNT_W-1:0] DOOR_LAST   = FRAME_CNT_W'(DOOR_FRAMES);
   localparam logic [FRAME_CNT_W-1:0] INVULN_LOAD = FRAME_CNT_W'(INVULN_FRAMES);
   localparam logic [HEALTH_W-1:0]    HEALTH_ONE  = HEALTH_W'(1);

   flow_state_t state, next_state;

   logic [FRAME_CNT_W-1:0] cnt;
   logic                   in_lvl, in_door;
   logic                   hit_sel, hit_ok;
   logic                   cnt_clr, cnt_load;
   logic [2:0]             level_d, door_d;
   logic                   initial_d, final_d, over_d, soft_d;

   // The door counter and the invuln counter are never live in the same
   // state, so a single counter serves both and is cleared on every state
   // change.
   frame_tick_gen u_tick (
      .Clk        (Clk),
      .Reset      (Reset),
      .frame_clk  (frame_clk),
      .clr        (cnt_clr),
      .load       (cnt_load),
      .load_val   (INVULN_LOAD),
      .count_down (in_lvl),
      .count      (cnt)
   );

   always_ff @(posedge Clk) begin
      if (Reset) state <= ST_INIT;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      in_lvl     = 1'b0;
      in_door    = 1'b0;
      hit_sel    = 1'b0;
      unique case (state)
         ST_INIT:  if (key_match(keycode, START_KEY)) next_state = ST_LVL1;
         ST_LVL1: begin
            in_lvl  = 1'b1;
            hit_sel = hit[0];
            if (Health == '0)   next_state = ST_DEAD;
            else if (finish[0]) next_state = ST_DOOR1;
         end
         ST_LVL2: begin
            in_lvl  = 1'b1;
            hit_sel = hit[1];
            if (Health == '0)   next_state = ST_DEAD;
            else if (finish[1]) next_state = ST_DOOR2;
         end
         ST_LVL3: begin
            in_lvl  = 1'b1;
            hit_sel = hit[2];
            if (Health == '0)   next_state = ST_DEAD;
            else if (finish[2]) next_state = ST_DOOR3;
         end
         ST_DOOR1: begin
            in_door = 1'b1;
            if (Health == '0)        next_state = ST_DEAD;
            else if (cnt == DOOR_LAST) next_state = ST_LVL2;
         end
         ST_DOOR2: begin
            in_door = 1'b1;
            if (Health == '0)        next_state = ST_DEAD;
            else if (cnt == DOOR_LAST) next_state = ST_LVL3;
         end
         ST_DOOR3: begin
            in_door = 1'b1;
            if (Health == '0)        next_state = ST_DEAD;
            else if (cnt == DOOR_LAST) next_state = ST_WIN;
         end
         ST_WIN, ST_DEAD: if (key_match(keycode, RESTART_KEY)) next_state = ST_INIT;
         default:  next_state = ST_INIT;
      endcase

`ifdef DMG_INVULN_EN
      hit_ok   = hit_sel && (cnt == '0);
      cnt_clr  = (next_state != state) || !(in_door || in_lvl);
      cnt_load = in_lvl && hit_ok;
`else
      hit_ok   = hit_sel;
      cnt_clr  = (next_state != state) || !in_door;
      cnt_load = 1'b0;
`endif

      // Outputs are registered from the next state so they line up with
      // the state register without an extra cycle.
      level_d   = 3'b000;
      door_d    = 3'b000;
      initial_d = 1'b0;
      final_d   = 1'b0;
      over_d    = 1'b0;
      unique case (next_state)
         ST_INIT:  initial_d = 1'b1;
         ST_LVL1:  level_d   = 3'b001;
         ST_LVL2:  level_d   = 3'b010;
         ST_LVL3:  level_d   = 3'b100;
         ST_DOOR1: door_d    = 3'b001;
         ST_DOOR2: door_d    = 3'b010;
         ST_DOOR3: door_d    = 3'b100;
         ST_WIN:   final_d   = 1'b1;
         ST_DEAD:  over_d    = 1'b1;
         default:  initial_d = 1'b1;
      endcase
      soft_d = ((state == ST_WIN) || (state == ST_DEAD)) && (next_state == ST_INIT);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         level_active  <= 3'b000;
         door_active   <= 3'b000;
         initial_frame <= 1'b1;
         final_frame   <= 1'b0;
         game_over     <= 1'b0;
         soft_reset    <= 1'b0;
      end else begin
         level_active  <= level_d;
         door_active   <= door_d;
         initial_frame <= initial_d;
         final_frame   <= final_d;
         game_over     <= over_d;
         soft_reset    <= soft_d;
      end
   end

   // Loading on the transition into INIT (not only while in it) means a
   // restarted run shows full health on its first title-screen cycle.
   always_ff @(posedge Clk) begin
      if (Reset || (next_state == ST_INIT)) begin
         Health <= HEALTH_MAX;
      end else if (hit_ok && (Health != '0)) begin
         Health <= Health - HEALTH_ONE;
      end
   end

   assign active_key = |keycode;

endmodule

// File: tb/tb_dungeon_flow_ctrl.sv
module tb_dungeon_flow_ctrl;

   localparam int DOOR_N = 60;
   localparam int INV_N  = 30;
   localparam int HMAX   = 7;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        frame_clk = 1'b0;
   logic [15:0] keycode = 16'h0000;
   logic [2:0]  finish = 3'b000;
   logic [2:0]  hit = 3'b000;
   logic [2:0]  level_active, door_active;
   logic        initial_frame, final_frame, game_over, soft_reset, active_key;
   logic [2:0]  Health;

   always #5 Clk = ~Clk;

   dungeon_flow_ctrl dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .frame_clk     (frame_clk),
      .keycode       (keycode),
      .finish        (finish),
      .hit           (hit),
      .level_active  (level_active),
      .door_active   (door_active),
      .initial_frame (initial_frame),
      .final_frame   (final_frame),
      .game_over     (game_over),
      .soft_reset    (soft_reset),
      .active_key    (active_key),
      .Health        (Health)
   );

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: where the player is (0 title, 1 level, 2 door, 3 win, 4 dead),
   // which level/door number, health, door tick count, immunity ticks left.
   int m_phase = 0, m_idx = 1, m_health = HMAX, m_ticks = 0, m_inv = 0;
   bit m_soft = 1'b0, m_fq = 1'b0;

   function automatic logic [2:0] onehot(input int i);
      return 3'b001 << (i - 1);
   endfunction

   always @(posedge Clk) begin
      bit tick, start_k, restart_k, acc;
      int nphase, nidx;
      tick = frame_clk && !m_fq;
      m_fq = frame_clk;
      if (Reset) begin
         m_phase = 0; m_idx = 1; m_health = HMAX; m_ticks = 0; m_inv = 0; m_soft = 0; m_fq = 0;
      end else begin
         start_k   = (keycode[15:8] == 8'h28) || (keycode[7:0] == 8'h28);
         restart_k = (keycode[15:8] == 8'h15) || (keycode[7:0] == 8'h15);
         m_soft = 0;
         nphase = m_phase;
         nidx   = m_idx;
         case (m_phase)
            0: begin
               m_health = HMAX;
               if (start_k) begin nphase = 1; nidx = 1; end
            end
            1: begin
               acc = hit[m_idx-1];
`ifdef DMG_INVULN_EN
               if (m_inv != 0) acc = 0;
`endif
               if (m_health == 0) nphase = 4;
               else if (finish[m_idx-1]) nphase = 2;
               if (acc && m_health > 0) m_health = m_health - 1;
               if (nphase != 1) m_inv = 0;
`ifdef DMG_INVULN_EN
               else if (acc) m_inv = INV_N;
               else if (tick && m_inv > 0) m_inv = m_inv - 1;
`endif
               if (nphase == 2) m_ticks = 0;
            end
            2: begin
               if (m_health == 0) nphase = 4;
               else if (m_ticks == DOOR_N) begin
                  if (m_idx == 3) nphase = 3;
                  else begin nphase = 1; nidx = m_idx + 1; end
               end else if (tick && m_ticks < 255) m_ticks = m_ticks + 1;
            end
            default: begin
               if (restart_k) begin nphase = 0; m_soft = 1; m_health = HMAX; end
            end
         endcase
         m_phase = nphase;
         m_idx   = nidx;
      end
   end

   always @(negedge Clk) begin
      if (chk_en) begin
         check("level_active", level_active, (m_phase == 1) ? onehot(m_idx) : 3'b000);
         check("door_active", door_active, (m_phase == 2) ? onehot(m_idx) : 3'b000);
         check("initial_frame", initial_frame, m_phase == 0);
         check("final_frame", final_frame, m_phase == 3);
         check("game_over", game_over, m_phase == 4);
         check("soft_reset", soft_reset, m_soft);
         check("active_key", active_key, keycode != 16'h0);
         check("Health", Health, m_health[2:0]);
      end
   end

   task automatic cyc();
      @(posedge Clk);
      #2;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         frame_clk = 1'b1; cyc();
         frame_clk = 1'b0; cyc();
      end
   endtask

   task automatic pulse_hit(input logic [2:0] v);
      hit = v; cyc(); hit = 3'b000;
   endtask

   initial begin
      Reset = 1'b1;
      cyc();
      chk_en = 1'b1;
      cyc();
      Reset = 1'b0;
      check("rst_initial_frame", initial_frame, 1);
      check("rst_health", Health, 7);
      check("rst_level", level_active, 0);
      check("rst_door", door_active, 0);

      // Run 1: full clear to the win screen
      keycode = 16'h0028; cyc(); keycode = 16'h0000;
      check("start_level", level_active, 3'b001);
      check("start_health", Health, 7);
      for (int i = 0; i < 3; i++) begin
         pulse_hit(3'b001);
         frames(INV_N + 2);
      end
      check("three_hits", Health, 4);
      pulse_hit(3'b010); cyc();
      check("foreign_hit", Health, 4);
      pulse_hit(3'b001); frames(5); pulse_hit(3'b001); cyc();
`ifdef DMG_INVULN_EN
      check("close_hits", Health, 3);
`else
      check("close_hits", Health, 2);
`endif
      frames(INV_N + 2);

      finish = 3'b001; cyc(); finish = 3'b000;
      check("door1", door_active, 3'b001);
      check("door1_no_level", level_active, 3'b000);
      frames(DOOR_N - 1);
      check("door1_hold", door_active, 3'b001);
      frames(1);
      check("lvl2", level_active, 3'b010);
      finish = 3'b011; cyc(); finish = 3'b000;
      check("door2", door_active, 3'b010);
      frames(DOOR_N);
      check("lvl3", level_active, 3'b100);
      finish = 3'b100; cyc(); finish = 3'b000;
      check("door3", door_active, 3'b100);
      frames(DOOR_N);
      check("win", final_frame, 1);
      keycode = 16'h0028; cyc(); cyc();
      check("win_ignores_start", final_frame, 1);
      keycode = 16'h0015; cyc();
      check("restart_soft", soft_reset, 1);
      check("restart_init", initial_frame, 1);
      check("restart_health", Health, 7);
      cyc();
      check("soft_one_cycle", soft_reset, 0);
      check("held_restart_stays", initial_frame, 1);
      keycode = 16'h0000;

      // Run 2: hit and finish together at health 1
      keycode = 16'h2800; cyc(); keycode = 16'h0000;
      check("run2_lvl1", level_active, 3'b001);
      finish = 3'b001; cyc(); finish = 3'b000;
      frames(DOOR_N);
      check("run2_lvl2", level_active, 3'b010);
      for (int i = 0; i < 8 && m_health > 1; i++) begin
         pulse_hit(3'b010);
         frames(INV_N + 2);
      end
      check("health_one", Health, 1);
      hit = 3'b010; finish = 3'b010; cyc(); hit = 3'b000; finish = 3'b000;
      check("hitfin_door2", door_active, 3'b010);
      check("hitfin_health", Health, 0);
      cyc();
      check("hitfin_dead", game_over, 1);
      keycode = 16'h1500; cyc(); keycode = 16'h0000;
      check("dead_restart_soft", soft_reset, 1);
      check("dead_restart_health", Health, 7);
      cyc();
      check("dead_soft_drop", soft_reset, 0);

      // Run 3: death by hits in level 1, then reset mid-door 2
      keycode = 16'h0028; cyc(); keycode = 16'h0000;
      for (int i = 0; i < HMAX; i++) begin
         pulse_hit(3'b001);
         frames(INV_N + 2);
      end
      check("hits_dead", game_over, 1);
      pulse_hit(3'b001); cyc();
      check("dead_health_sat", Health, 0);
      keycode = 16'h0015; cyc(); keycode = 16'h0000;
      keycode = 16'h0028; cyc(); keycode = 16'h0000;
      finish = 3'b001; cyc(); finish = 3'b000;
      frames(DOOR_N);
      finish = 3'b010; cyc(); finish = 3'b000;
      frames(10);
      check("mid_door2", door_active, 3'b010);
      Reset = 1'b1; cyc(); Reset = 1'b0;
      check("mid_rst_initial", initial_frame, 1);
      check("mid_rst_door", door_active, 0);
      check("mid_rst_level", level_active, 0);
      check("mid_rst_final", final_frame, 0);
      check("mid_rst_over", game_over, 0);
      check("mid_rst_soft", soft_reset, 0);
      check("mid_rst_health", Health, 7);
      keycode = 16'h0028; cyc(); keycode = 16'h0000;
      finish = 3'b001; cyc(); finish = 3'b000;
      frames(DOOR_N - 1);
      check("post_rst_door_hold", door_active, 3'b001);
      frames(1);
      check("post_rst_lvl2", level_active, 3'b010);
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
